// File: rtl/pe_req_scheduler_if.sv
// Request/grant bundle between the requesters and the scheduler.
// The master side drives requests, masks, enable and done; the slave
// side (the scheduler) returns grant and encoder-style status.
interface pe_req_scheduler_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic             en_i;
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] mask_i;
    logic             done_i;
    logic [N_REQ-1:0] grant_o;
    logic [IDX_W-1:0] grant_idx_o;
    logic             grant_valid_o;
    logic [N_REQ-1:0] pending_o;
    logic             gs_o;
    logic             eno_o;
    logic             timeout_o;

    modport master (
        output en_i, req_i, mask_i, done_i,
        input  grant_o, grant_idx_o, grant_valid_o, pending_o, gs_o, eno_o, timeout_o
    );

    modport slave (
        input  en_i, req_i, mask_i, done_i,
        output grant_o, grant_idx_o, grant_valid_o, pending_o, gs_o, eno_o, timeout_o
    );
endinterface

// File: rtl/pe_req_scheduler.sv
// Fixed-priority request scheduler. Requests are latched into a sticky
// pending register; the highest-index pending, unmasked requester is
// granted and keeps the grant until it reports done or the hold timer
// expires. Every release is followed by a GAP cycle and an IDLE cycle,
// so consecutive grants are always separated by idle time.
module pe_req_scheduler #(
    parameter int N_REQ   = 8,
    parameter int IDX_W   = 3,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    pe_req_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic             grant_valid_q;
    logic             timeout_q;
    logic [TO_W-1:0]  count;
    logic [IDX_W-1:0] enc_idx;
    logic             any_eligible;
    logic             timeout_reached;
    logic             load_grant;
    logic             done_hit;
    logic             timeout_hit;
    logic             release_grant;

    assign eligible        = pending & ~bus.mask_i;
    assign any_eligible    = |eligible;
    assign timeout_reached = (count == TO_W'(TIMEOUT - 1));

    // Priority encoder: ascending scan so the highest set index wins.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (eligible[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: a grant ends on done or hold-timer expiry.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en_i && any_eligible) state_nx = GRANT;
            GRANT:   if (bus.done_i || timeout_reached) state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control decode; done takes precedence over a coincident timeout.
    always_comb begin
        load_grant    = (state == IDLE) && bus.en_i && any_eligible;
        done_hit      = (state == GRANT) && bus.done_i;
        timeout_hit   = (state == GRANT) && !bus.done_i && timeout_reached;
        release_grant = done_hit || timeout_hit;
        clr           = release_grant ? grant_q : '0;
    end

    // Datapath registers; a request arriving with the release re-arms its bit.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pending       <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            count         <= '0;
        end else begin
            pending   <= (pending & ~clr) | (bus.req_i & ~bus.mask_i);
            timeout_q <= timeout_hit;
            if (load_grant) begin
                grant_idx_q   <= enc_idx;
                grant_q       <= N_REQ'(1) << enc_idx;
                grant_valid_q <= 1'b1;
                count         <= '0;
            end else if (release_grant) begin
                grant_q       <= '0;
                grant_valid_q <= 1'b0;
            end else if (state == GRANT) begin
                count <= count + 1'b1;
            end
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_idx_o   = grant_idx_q;
    assign bus.grant_valid_o = grant_valid_q;
    assign bus.pending_o     = pending;
    assign bus.timeout_o     = timeout_q;
    assign bus.gs_o          = bus.en_i & any_eligible;
    assign bus.eno_o         = bus.en_i & ~any_eligible;

endmodule
